ram_dp: RTL and testbench
=========================

Name: ram_dp

Overview:
- Unified instruction/data memory for the simulation build of the RISC-V core.
- Storage is an array of 16-bit halfwords, so instruction fetch can be halfword-aligned (compressed instructions).
- One read-only instruction port, addressed per halfword.
- One read/write data port, addressed per data word of BURST halfwords.
- Sits between the cpu and the address/data bus decoders.

Parameters:
- DEPTH, 1048576: number of 16-bit halfword entries. Must be a power of two.
- BURST, 2: halfwords per access. Data width DW = 16*BURST (2 gives 32 bits, 4 gives 64 bits).
- ADDR_W, 32: width of both address ports.

Ports:
- clock  in  1  single clock; writes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- write_en  in  1  data-port write strobe.
- iaddr  in  ADDR_W  instruction halfword address (pc>>1).
- daddr  in  ADDR_W  data word address, in units of BURST halfwords.
- data_i  in  DW  write data.
- data_o  out  DW  data-port read data.
- inst_o  out  DW  instruction-port read data.

Behaviour:
- Halfword index arithmetic:
  - Instruction base index = iaddr mod DEPTH.
  - Data base index = (daddr*BURST) mod DEPTH.
  - Each of the BURST lanes adds its lane number to the base, then wraps modulo DEPTH. A fetch at DEPTH-1 returns lane 0 = entry DEPTH-1 and lane 1 = entry 0.
- Lane packing is little-endian for both ports and for writes:
  - Lane k occupies bits [16k+15:16k].
  - inst_o lane k = words[iaddr+k].
  - data_o lane k = words[daddr*BURST+k].
- Instruction port: no alignment requirement. An odd iaddr returns a straddling word, e.g. iaddr=1 gives {words[2], words[1]}.
- Read timing (default): both ports are combinational. Outputs follow address and array contents in the same cycle.
- Write timing:
  - On a rising clock edge with write_en=1 and reset=1, all BURST lanes of data_i are written at the data base index.
  - No byte enables; callers perform read-modify-write.
- Read-during-write: combinational reads show old contents until the edge and new contents after it. The instruction port sees data-port writes.
- Reset:
  - While reset=0, writes are suppressed.
  - Array contents are never cleared by reset, so a backdoor preload survives reset.
  - Deasserting reset mid-operation resumes normal writes on the next edge.
- Uninitialised entries read as X in simulation. There is no requirement to zero them.
- Backdoor load: the array is reachable hierarchically as <instance>.mem_inst.words, declared [0:DEPTH-1] of 16 bits. This lets $readmemh and $writememh load and dump it by halfword index.

Optional Feature:
- Macro: RAM_DP_REG_OUT_EN.
- Defined:
  - data_o and inst_o are registered with one-cycle latency, sampling on the rising edge.
  - Read-first on address collision: data_o returns pre-write contents.
  - Both output registers clear to 0 asynchronously while reset=0.
- Undefined: combinational reads as above; no output registers exist.

Decomposition:
- Shared package holds:
  - HALF_W=16.
  - A function computing the wrapped lane index from (base, lane, DEPTH).
  - A DW localparam helper.
- One sub-module, ram_dp_array, instance name mem_inst. It holds the `words` array and the write logic, and provides two combinational halfword-burst read ports.
- ram_dp wraps it with address scaling and the optional output registers.

Test Plan:
- Preload words[0..3]=0x1111,0x2222,0x3333,0x4444; iaddr=0 -> inst_o=0x22221111; iaddr=1 -> inst_o=0x33332222.
- write_en=1, daddr=1, data_i=0xDEADBEEF, one edge -> words[2]=0xBEEF, words[3]=0xDEAD; data_o at daddr=1 = 0xDEADBEEF; inst_o at iaddr=2 = 0xDEADBEEF.
- reset=0 with write_en=1, daddr=0, data_i=0x12345678 -> after edge data_o at daddr=0 still 0x22221111; release reset, repeat -> 0x12345678.
- Wrap with DEPTH=16: iaddr=15 after words[15]=0xAAAA and words[0]=0x5555 -> inst_o=0x5555AAAA; daddr=8 aliases daddr=0.
- BURST=4 (DW=64): write daddr=2 data 0x0123456789ABCDEF -> words[8..11]=CDEF,89AB,4567,0123; fetch iaddr=9 -> 0x????0123456789AB with top lane = words[12].
- RAM_DP_REG_OUT_EN defined: change daddr -> data_o updates one edge later; write and read same address on one edge -> data_o shows old value, new value the following cycle; assert reset -> both outputs 0 immediately.

Source files
------------

// File: rtl/ram_dp_pkg.sv
// Shared constants and index helpers for the dual-port halfword RAM.
package ram_dp_pkg;

  localparam int HALF_W = 16;

  // Data width in bits for a given number of halfword lanes.
  function automatic int dw_of(input int burst);
    return HALF_W * burst;
  endfunction

  // Halfword index of one lane of a burst, wrapped into a power-of-two array.
  function automatic logic [31:0] lane_idx(input logic [31:0] base,
                                           input int          lane,
                                           input int          depth);
    return (base + 32'(lane)) & (32'(depth) - 32'd1);
  endfunction

endpackage

// File: rtl/ram_dp_array.sv
// Halfword storage with one burst write port and two combinational burst read ports.
module ram_dp_array
  import ram_dp_pkg::*;
#(
  parameter  int DEPTH = 1048576,
  parameter  int BURST = 2,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int DW    = dw_of(BURST)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write_en,
  input  logic [IDX_W-1:0] wr_base,
  input  logic [DW-1:0]    wr_data,
  input  logic [IDX_W-1:0] ra_base,
  output logic [DW-1:0]    ra_data,
  input  logic [IDX_W-1:0] rb_base,
  output logic [DW-1:0]    rb_data
);

  logic [HALF_W-1:0] words [0:DEPTH-1];

  logic [IDX_W-1:0] wr_idx [BURST];
  logic [IDX_W-1:0] ra_idx [BURST];
  logic [IDX_W-1:0] rb_idx [BURST];

  for (genvar k = 0; k < BURST; k++) begin : g_lane
    assign wr_idx[k] = IDX_W'(lane_idx(32'(wr_base), k, DEPTH));
    assign ra_idx[k] = IDX_W'(lane_idx(32'(ra_base), k, DEPTH));
    assign rb_idx[k] = IDX_W'(lane_idx(32'(rb_base), k, DEPTH));
    assign ra_data[k*HALF_W +: HALF_W] = words[ra_idx[k]];
    assign rb_data[k*HALF_W +: HALF_W] = words[rb_idx[k]];
  end

  // Contents are deliberately not cleared by reset so a preload survives it.
  always_ff @(posedge clock) begin
    if (reset && write_en) begin
      for (int k = 0; k < BURST; k++) begin
        words[wr_idx[k]] <= wr_data[k*HALF_W +: HALF_W];
      end
    end
  end

endmodule

// File: rtl/ram_dp.sv
// Unified instruction/data RAM: halfword-addressed fetch port, burst-addressed data port.
// Define RAM_DP_REG_OUT_EN to register both read outputs (one-cycle latency).
module ram_dp
  import ram_dp_pkg::*;
#(
  parameter  int DEPTH  = 1048576,
  parameter  int BURST  = 2,
  parameter  int ADDR_W = 32,
  localparam int DW     = dw_of(BURST)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DW-1:0]     data_i,
  output logic [DW-1:0]     data_o,
  output logic [DW-1:0]     inst_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] dscaled;
  logic [IDX_W-1:0]  ibase;
  logic [IDX_W-1:0]  dbase;
  logic [DW-1:0]     inst_rd;
  logic [DW-1:0]     data_rd;

  // Truncation to the index width is the modulo-DEPTH wrap.
  assign dscaled = daddr * ADDR_W'(BURST);
  assign ibase   = IDX_W'(iaddr);
  assign dbase   = IDX_W'(dscaled);

  ram_dp_array #(
    .DEPTH (DEPTH),
    .BURST (BURST)
  ) mem_inst (
    .clock    (clock),
    .reset    (reset),
    .write_en (write_en),
    .wr_base  (dbase),
    .wr_data  (data_i),
    .ra_base  (ibase),
    .ra_data  (inst_rd),
    .rb_base  (dbase),
    .rb_data  (data_rd)
  );

`ifdef RAM_DP_REG_OUT_EN
  // Sampling the combinational read at the write edge gives read-first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_o <= '0;
      inst_o <= '0;
    end else begin
      data_o <= data_rd;
      inst_o <= inst_rd;
    end
  end
`else
  assign data_o = data_rd;
  assign inst_o = inst_rd;
`endif

endmodule

// File: tb/tb_ram_dp.sv
// Directed self-checking bench for ram_dp (BURST=2 and BURST=4, DEPTH=16).
module tb_ram_dp;

  logic        clock;
  logic        reset;

  logic        we_a;
  logic [31:0] iaddr_a, daddr_a;
  logic [31:0] din_a, dout_a, inst_a;

  logic        we_b;
  logic [31:0] iaddr_b, daddr_b;
  logic [63:0] din_b, dout_b, inst_b;

  int checks = 0;
  int errors = 0;

  ram_dp #(.DEPTH(16), .BURST(2), .ADDR_W(32)) u_dut_a (
    .clock    (clock),
    .reset    (reset),
    .write_en (we_a),
    .iaddr    (iaddr_a),
    .daddr    (daddr_a),
    .data_i   (din_a),
    .data_o   (dout_a),
    .inst_o   (inst_a)
  );

  ram_dp #(.DEPTH(16), .BURST(4), .ADDR_W(32)) u_dut_b (
    .clock    (clock),
    .reset    (reset),
    .write_en (we_b),
    .iaddr    (iaddr_b),
    .daddr    (daddr_b),
    .data_i   (din_b),
    .data_o   (dout_b),
    .inst_o   (inst_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Let read data settle: same cycle when combinational, one edge when registered.
  task automatic settle();
`ifdef RAM_DP_REG_OUT_EN
    @(posedge clock);
`endif
    #1;
  endtask

  task automatic wr_a(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    daddr_a = a; din_a = d; we_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    we_a = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    we_a = 1'b0; iaddr_a = '0; daddr_a = '0; din_a = '0;
    we_b = 1'b0; iaddr_b = '0; daddr_b = '0; din_b = '0;

    #2;
`ifdef RAM_DP_REG_OUT_EN
    chk("rst_data_o", 64'(dout_a), 64'h0);
    chk("rst_inst_o", 64'(inst_a), 64'h0);
`endif
    @(negedge clock);
    reset = 1'b1;

    u_dut_a.mem_inst.words[0] = 16'h1111;
    u_dut_a.mem_inst.words[1] = 16'h2222;
    u_dut_a.mem_inst.words[2] = 16'h3333;
    u_dut_a.mem_inst.words[3] = 16'h4444;

    iaddr_a = 32'd0; daddr_a = 32'd0;
    settle();
    chk("inst_i0", 64'(inst_a), 64'h22221111);
    chk("data_d0", 64'(dout_a), 64'h22221111);
    iaddr_a = 32'd1; daddr_a = 32'd1;
    settle();
    chk("inst_i1_straddle", 64'(inst_a), 64'h33332222);
    chk("data_d1_before", 64'(dout_a), 64'h44443333);

    wr_a(32'd1, 32'hDEADBEEF);
    chk("word2", 64'(u_dut_a.mem_inst.words[2]), 64'hBEEF);
    chk("word3", 64'(u_dut_a.mem_inst.words[3]), 64'hDEAD);
    iaddr_a = 32'd2;
    settle();
    chk("data_d1_after", 64'(dout_a), 64'hDEADBEEF);
    chk("inst_sees_write", 64'(inst_a), 64'hDEADBEEF);

    // Writes held off while reset is low, resumed once it is released.
    @(negedge clock);
    reset = 1'b0; daddr_a = 32'd0; din_a = 32'h12345678; we_a = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_block_w0", 64'(u_dut_a.mem_inst.words[0]), 64'h1111);
    chk("rst_block_w1", 64'(u_dut_a.mem_inst.words[1]), 64'h2222);
`ifdef RAM_DP_REG_OUT_EN
    chk("rst_hold_data_o", 64'(dout_a), 64'h0);
`else
    chk("rst_block_data_o", 64'(dout_a), 64'h22221111);
`endif
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    we_a = 1'b0;
    settle();
    chk("post_rst_write", 64'(dout_a), 64'h12345678);

    // Wrap at DEPTH-1 and data-address aliasing.
    u_dut_a.mem_inst.words[15] = 16'hAAAA;
    u_dut_a.mem_inst.words[0]  = 16'h5555;
    iaddr_a = 32'd15; daddr_a = 32'd8;
    settle();
    chk("inst_wrap", 64'(inst_a), 64'h5555AAAA);
    chk("daddr8_alias", 64'(dout_a), 64'h12345555);
    wr_a(32'd8, 32'hCAFEF00D);
    daddr_a = 32'd0;
    settle();
    chk("alias_write", 64'(dout_a), 64'hCAFEF00D);

`ifdef RAM_DP_REG_OUT_EN
    // Registered output: latency, read-first collision, async clear.
    @(negedge clock);
    daddr_a = 32'd1;
    #1;
    chk("reg_latency_old", 64'(dout_a), 64'hCAFEF00D);
    @(posedge clock);
    #1;
    chk("reg_latency_new", 64'(dout_a), 64'hDEADBEEF);
    @(negedge clock);
    din_a = 32'h0BADC0DE; we_a = 1'b1;
    @(posedge clock);
    #1;
    chk("read_first_old", 64'(dout_a), 64'hDEADBEEF);
    @(negedge clock);
    we_a = 1'b0;
    @(posedge clock);
    #1;
    chk("read_first_new", 64'(dout_a), 64'h0BADC0DE);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("async_clr_data", 64'(dout_a), 64'h0);
    chk("async_clr_inst", 64'(inst_a), 64'h0);
    @(negedge clock);
    reset = 1'b1;
`endif

    // BURST=4 instance: 64-bit data word, base index = daddr*4.
    u_dut_b.mem_inst.words[12] = 16'h7777;
    @(negedge clock);
    daddr_b = 32'd2; din_b = 64'h0123456789ABCDEF; we_b = 1'b1;
    @(posedge clock);
    @(negedge clock);
    we_b = 1'b0;
    chk("b_word8",  64'(u_dut_b.mem_inst.words[8]),  64'hCDEF);
    chk("b_word9",  64'(u_dut_b.mem_inst.words[9]),  64'h89AB);
    chk("b_word10", 64'(u_dut_b.mem_inst.words[10]), 64'h4567);
    chk("b_word11", 64'(u_dut_b.mem_inst.words[11]), 64'h0123);
    iaddr_b = 32'd9;
    settle();
    chk("b_data_d2", dout_b, 64'h0123456789ABCDEF);
    chk("b_inst_i9", inst_b, 64'h77770123456789AB);
    daddr_b = 32'd6;
    settle();
    chk("b_daddr6_alias", dout_b, 64'h0123456789ABCDEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
